// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, write-back select,
// qualified register-file write enable and a retired-instruction counter.
module mem_wb_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [XLEN-1:0]  i_ReadData,
    input  logic [XLEN-1:0]  i_Mux,
    input  logic [XLEN-1:0]  i_PCplus4,
    input  logic [4:0]       i_rd,
    input  logic             i_RegWrite,
    input  logic [1:0]       i_MemToReg,
    input  logic [2:0]       i_LoadType,
    input  logic [1:0]       i_ByteOffset,
    output logic [XLEN-1:0]  o_WriteData,
    output logic [4:0]       o_rd,
    output logic             o_RegWrite,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC   = 2'b10,
        WB_ALT  = 2'b11
    } wb_sel_e;

    typedef enum logic [2:0] {
        LD_B   = 3'b000,
        LD_H   = 3'b001,
        LD_W   = 3'b010,
        LD_R3  = 3'b011,
        LD_BU  = 3'b100,
        LD_HU  = 3'b101,
        LD_R6  = 3'b110,
        LD_R7  = 3'b111
    } load_e;

    logic             valid_q;
    logic             regwrite_q;
    logic [4:0]       rd_q;
    wb_sel_e          memtoreg_q;
    load_e            loadtype_q;
    logic [1:0]       byteoff_q;
    logic [XLEN-1:0]  readdata_q;
    logic [XLEN-1:0]  mux_q;
    logic [XLEN-1:0]  pcplus4_q;
    logic [CNT_W-1:0] retired_q;

    logic             capture;
    logic [7:0]       load_byte;
    logic [15:0]      load_half;
    logic [XLEN-1:0]  load_value;

    assign capture = !i_flush && !i_stall;

    // Flush takes priority over stall: control is cleared, payload still loads.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            memtoreg_q <= WB_ALU;
            loadtype_q <= LD_B;
            byteoff_q  <= '0;
            readdata_q <= '0;
            mux_q      <= '0;
            pcplus4_q  <= '0;
            retired_q  <= '0;
        end else if (i_flush || !i_stall) begin
            valid_q    <= i_flush ? 1'b0 : i_valid;
            regwrite_q <= i_flush ? 1'b0 : i_RegWrite;
            rd_q       <= i_rd;
            memtoreg_q <= wb_sel_e'(i_MemToReg);
            loadtype_q <= load_e'(i_LoadType);
            byteoff_q  <= i_ByteOffset;
            readdata_q <= i_ReadData;
            mux_q      <= i_Mux;
            pcplus4_q  <= i_PCplus4;
            if (capture && i_valid) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    assign load_byte = readdata_q[{byteoff_q, 3'b000} +: 8];
    assign load_half = readdata_q[{byteoff_q[1], 4'b0000} +: 16];

    always_comb begin
        load_value = readdata_q;
        case (loadtype_q)
            LD_B:    load_value = {{(XLEN-8){load_byte[7]}}, load_byte};
            LD_BU:   load_value = {{(XLEN-8){1'b0}}, load_byte};
            LD_H:    load_value = {{(XLEN-16){load_half[15]}}, load_half};
            LD_HU:   load_value = {{(XLEN-16){1'b0}}, load_half};
            default: load_value = readdata_q;
        endcase
    end

    always_comb begin
        o_WriteData = mux_q;
        case (memtoreg_q)
            WB_LOAD: o_WriteData = load_value;
            WB_PC:   o_WriteData = pcplus4_q;
            default: o_WriteData = mux_q;
        endcase
    end

    assign o_rd       = rd_q;
    assign o_valid    = valid_q;
    assign o_RegWrite = valid_q && regwrite_q && (rd_q != 5'd0);
    assign o_retired  = retired_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural model;
// a narrow-counter instance shares the stimulus to exercise counter wrap.
module tb_mem_wb_stage;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_stall = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_ReadData = '0;
    logic [31:0] i_Mux = '0;
    logic [31:0] i_PCplus4 = '0;
    logic [4:0]  i_rd = '0;
    logic        i_RegWrite = 1'b0;
    logic [1:0]  i_MemToReg = '0;
    logic [2:0]  i_LoadType = '0;
    logic [1:0]  i_ByteOffset = '0;

    logic [31:0] o_WriteData;
    logic [4:0]  o_rd;
    logic        o_RegWrite;
    logic        o_valid;
    logic [63:0] o_retired;

    logic [31:0] s_WriteData;
    logic [4:0]  s_rd;
    logic        s_RegWrite;
    logic        s_valid;
    logic [2:0]  s_retired;

    mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_flush(i_flush), .i_ReadData(i_ReadData), .i_Mux(i_Mux),
        .i_PCplus4(i_PCplus4), .i_rd(i_rd), .i_RegWrite(i_RegWrite),
        .i_MemToReg(i_MemToReg), .i_LoadType(i_LoadType), .i_ByteOffset(i_ByteOffset),
        .o_WriteData(o_WriteData), .o_rd(o_rd), .o_RegWrite(o_RegWrite),
        .o_valid(o_valid), .o_retired(o_retired)
    );

    mem_wb_stage #(.XLEN(32), .CNT_W(3)) dut_small (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .i_stall(i_stall),
        .i_flush(i_flush), .i_ReadData(i_ReadData), .i_Mux(i_Mux),
        .i_PCplus4(i_PCplus4), .i_rd(i_rd), .i_RegWrite(i_RegWrite),
        .i_MemToReg(i_MemToReg), .i_LoadType(i_LoadType), .i_ByteOffset(i_ByteOffset),
        .o_WriteData(s_WriteData), .o_rd(s_rd), .o_RegWrite(s_RegWrite),
        .o_valid(s_valid), .o_retired(s_retired)
    );

    always #5 i_clk = ~i_clk;

    int unsigned total_cnt = 0;
    int unsigned pass_cnt  = 0;
    logic        chk_en    = 1'b0;

    // Model of what the WB stage currently holds.
    logic        m_valid, m_rw;
    logic [4:0]  m_rd;
    logic [1:0]  m_m2r, m_off;
    logic [2:0]  m_lt;
    logic [31:0] m_rdata, m_mux, m_pc;
    logic [63:0] m_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_valid = 0; m_rw = 0; m_rd = 0; m_m2r = 0; m_off = 0; m_lt = 0;
        m_rdata = 0; m_mux = 0; m_pc = 0; m_cnt = 0;
    endtask

    function automatic logic [31:0] exp_load();
        logic [31:0] sh;
        logic [7:0]  b;
        logic [15:0] h;
        sh = m_rdata >> (8 * m_off);
        b  = sh[7:0];
        sh = m_rdata >> (m_off[1] ? 16 : 0);
        h  = sh[15:0];
        case (m_lt)
            3'd0:    return 32'($signed(b));
            3'd4:    return 32'(b);
            3'd1:    return 32'($signed(h));
            3'd5:    return 32'(h);
            default: return m_rdata;
        endcase
    endfunction

    function automatic logic [31:0] exp_wd();
        if (m_m2r == 2'd1) return exp_load();
        if (m_m2r == 2'd2) return m_pc;
        return m_mux;
    endfunction

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("valid", {63'd0, o_valid}, {63'd0, m_valid});
            check("regwrite", {63'd0, o_RegWrite}, {63'd0, m_valid & m_rw & (m_rd != 0)});
            check("rd", {59'd0, o_rd}, {59'd0, m_rd});
            check("writedata", {32'd0, o_WriteData}, {32'd0, exp_wd()});
            check("retired", o_retired, m_cnt);
            check("retired_small", {61'd0, s_retired}, {61'd0, m_cnt[2:0]});
            check("valid_small", {63'd0, s_valid}, {63'd0, m_valid});
        end
    end

    task automatic step(input logic v, input logic st, input logic fl, input logic [4:0] rd,
                        input logic rw, input logic [1:0] m2r, input logic [2:0] lt,
                        input logic [1:0] off, input logic [31:0] rdat, input logic [31:0] mux,
                        input logic [31:0] pc);
        i_valid = v; i_stall = st; i_flush = fl; i_rd = rd; i_RegWrite = rw;
        i_MemToReg = m2r; i_LoadType = lt; i_ByteOffset = off;
        i_ReadData = rdat; i_Mux = mux; i_PCplus4 = pc;
        @(posedge i_clk);
        if (!i_reset && (fl || !st)) begin
            m_valid = fl ? 1'b0 : v;
            m_rw    = fl ? 1'b0 : rw;
            m_rd = rd; m_m2r = m2r; m_lt = lt; m_off = off;
            m_rdata = rdat; m_mux = mux; m_pc = pc;
            if (!fl && v) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        i_reset = 1'b1;
        model_reset();
        #1;
        check({tag, "_wd"}, {32'd0, o_WriteData}, 64'd0);
        check({tag, "_valid"}, {63'd0, o_valid}, 64'd0);
        check({tag, "_rw"}, {63'd0, o_RegWrite}, 64'd0);
        check({tag, "_rd"}, {59'd0, o_rd}, 64'd0);
        check({tag, "_retired"}, o_retired, 64'd0);
        @(negedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", {63'd0, o_valid}, 64'd0);
        check("rst_retired", o_retired, 64'd0);
        @(negedge i_clk);
        #1 i_reset = 1'b0;
        chk_en = 1'b1;

        // ALU write
        step(1, 0, 0, 5'd5, 1, 2'b00, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0000_0001, 32'h40);
        check("alu_wd", {32'd0, o_WriteData}, 64'h1);
        check("alu_rd", {59'd0, o_rd}, 64'd5);
        check("alu_rw", {63'd0, o_RegWrite}, 64'd1);
        check("alu_retired", o_retired, 64'd1);

        // Loads
        step(1, 0, 0, 5'd6, 1, 2'b01, 3'b000, 2'd0, 32'h80F1_7F82, 32'h0, 32'h0);
        check("lb_off0", {32'd0, o_WriteData}, 64'hFFFF_FF82);
        step(1, 0, 0, 5'd6, 1, 2'b01, 3'b100, 2'd3, 32'h80F1_7F82, 32'h0, 32'h0);
        check("lbu_off3", {32'd0, o_WriteData}, 64'h0000_0080);
        step(1, 0, 0, 5'd6, 1, 2'b01, 3'b001, 2'd2, 32'h80F1_7F82, 32'h0, 32'h0);
        check("lh_off2", {32'd0, o_WriteData}, 64'hFFFF_80F1);
        step(1, 0, 0, 5'd6, 1, 2'b01, 3'b101, 2'd1, 32'h80F1_7F82, 32'h0, 32'h0);
        check("lhu_off1", {32'd0, o_WriteData}, 64'h0000_7F82);
        step(1, 0, 0, 5'd6, 1, 2'b01, 3'b010, 2'd3, 32'h80F1_7F82, 32'h0, 32'h0);
        check("lw", {32'd0, o_WriteData}, 64'h80F1_7F82);

        // JAL link, then the same into x0
        step(1, 0, 0, 5'd1, 1, 2'b10, 3'd0, 2'd0, 32'h0, 32'h55, 32'h0000_0104);
        check("jal_wd", {32'd0, o_WriteData}, 64'h104);
        check("jal_rw", {63'd0, o_RegWrite}, 64'd1);
        step(1, 0, 0, 5'd0, 1, 2'b10, 3'd0, 2'd0, 32'h0, 32'h55, 32'h0000_0104);
        check("x0_rw", {63'd0, o_RegWrite}, 64'd0);
        check("x0_wd", {32'd0, o_WriteData}, 64'h104);
        check("x0_retired", o_retired, 64'd8);

        // Stall with changing inputs, then flush+stall
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 5'(i + 9), 1, 2'b00, 3'd0, 2'd0, $urandom, $urandom, $urandom);
            check("stall_wd", {32'd0, o_WriteData}, 64'h104);
            check("stall_rd", {59'd0, o_rd}, 64'd0);
            check("stall_retired", o_retired, 64'd8);
        end
        step(1, 1, 1, 5'd7, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'h77, 32'h0);
        check("flst_valid", {63'd0, o_valid}, 64'd0);
        check("flst_rw", {63'd0, o_RegWrite}, 64'd0);
        check("flst_retired", o_retired, 64'd8);

        // Reset during a stall, then first capture loads normally
        step(1, 1, 0, 5'd3, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'h9, 32'h0);
        i_stall = 1'b1;
        async_reset_check("rst_stall");
        step(1, 0, 0, 5'd3, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'h9, 32'h0);
        check("post_rst_valid", {63'd0, o_valid}, 64'd1);
        check("post_rst_wd", {32'd0, o_WriteData}, 64'h9);
        check("post_rst_retired", o_retired, 64'd1);

        // Counter wrap on the 3-bit instance
        for (int i = 0; i < 7; i++)
            step(1, 0, 0, 5'd2, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'(i), 32'h0);
        check("wrap_small", {61'd0, s_retired}, 64'd0);
        check("wrap_big", o_retired, 64'd8);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 6) == 0), 5'($urandom_range(0, 31)),
                 1'($urandom), 2'($urandom), 3'($urandom), 2'($urandom),
                 $urandom, $urandom, $urandom);
        end

        async_reset_check("rst_async");
        step(0, 0, 0, 5'd4, 1, 2'b00, 3'd0, 2'd0, 32'h0, 32'h3, 32'h0);
        check("bubble_rw", {63'd0, o_RegWrite}, 64'd0);
        check("bubble_retired", o_retired, 64'd0);

        @(posedge i_clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
